icb_sram_slave: RTL and testbench

ICB_SRAM_SLAVE -- requirements
Module: icb_sram_slave

---
 rtl/icb_pkg.sv | 16 +
 rtl/icb_rsp_fifo.sv | 61 ++++++
 rtl/icb_sram_slave.sv | 80 ++++++++
 tb/tb_icb_sram_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/icb_pkg.sv
// Shared ICB bus widths and the response-buffer entry type.
// Used by the SRAM slave and by its response FIFO.
package icb_pkg;

  localparam int unsigned ICB_AW = 32;
  localparam int unsigned ICB_DW = 32;
  localparam int unsigned ICB_MW = ICB_DW / 8;

  typedef struct packed {
    logic [ICB_DW-1:0] rdata;
    logic              err;
  } icb_rsp_t;

  localparam icb_rsp_t ICB_RSP_NONE = '0;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Two-entry in-order response buffer; a push into a full buffer is taken
// only when a pop happens on the same edge.
module icb_rsp_fifo
  import icb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  icb_rsp_t push_data_i,
  input  logic     pop_i,
  output icb_rsp_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  icb_rsp_t   entry_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) entry_q[i] <= ICB_RSP_NONE;
    end else if (do_push) begin
      entry_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Head is forced to zero when empty so idle response fields read as 0.
  assign pop_data_o = empty_o ? ICB_RSP_NONE : entry_q[rd_ptr_q];

endmodule

// File: rtl/icb_sram_slave.sv
// ICB slave backed by a DEPTH x 32 flop SRAM with byte enables; responses
// are queued in a 2-entry FIFO so one command per cycle can be sustained.
module icb_sram_slave
  import icb_pkg::*;
#(
  parameter logic [ICB_AW-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned       DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [ICB_AW-1:0] icb_cmd_addr,
  input  logic [ICB_DW-1:0] icb_cmd_wdata,
  input  logic [ICB_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [ICB_DW-1:0] icb_rsp_rdata,
  output logic              icb_rsp_err
);

  localparam int unsigned       IDXW      = $clog2(DEPTH);
  localparam logic [ICB_AW-1:0] WIN_BYTES = ICB_AW'(4 * DEPTH);

  logic [ICB_DW-1:0] mem_q [DEPTH];

  logic [ICB_AW-1:0] offset;
  logic [IDXW-1:0]   word_idx;
  logic              addr_err;
  logic              cmd_fire;
  logic              rsp_pop;
  logic              wr_en;
  logic              fifo_full, fifo_empty;
  icb_rsp_t          push_data, head;

  // Offset comparison avoids overflow of BASE_ADDR + window size.
  always_comb begin
    offset   = icb_cmd_addr - BASE_ADDR;
    word_idx = offset[IDXW+1:2];
    addr_err = (icb_cmd_addr[1:0] != 2'b00)
             | (icb_cmd_addr < BASE_ADDR)
             | (offset >= WIN_BYTES);
  end

  assign icb_rsp_valid = ~fifo_empty;
  assign rsp_pop       = icb_rsp_valid & icb_rsp_ready;
  assign icb_cmd_ready = ~rst & (~fifo_full | rsp_pop);
  assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
  assign wr_en         = cmd_fire & ~icb_cmd_read & ~addr_err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < ICB_MW; b++) begin
        if (icb_cmd_wmask[b]) mem_q[word_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    push_data       = ICB_RSP_NONE;
    push_data.err   = addr_err;
    if (icb_cmd_read && !addr_err) push_data.rdata = mem_q[word_idx];
  end

  icb_rsp_fifo u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_fire),
    .push_data_i (push_data),
    .pop_i       (rsp_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign icb_rsp_rdata = head.rdata;
  assign icb_rsp_err   = head.err;

endmodule

// File: tb/tb_icb_sram_slave.sv
// Randomized and directed bench for icb_sram_slave against a queue/array
// reference model of the slave's bus-level behaviour.
module tb_icb_sram_slave;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_addr = '0;
  logic [31:0] icb_cmd_wdata = '0;
  logic [3:0]  icb_cmd_wmask = '0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b0;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  icb_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [32:0] exp_q [$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rdata;
  logic        last_err;
  logic        last_dut_acc;
  logic        obs_valid;
  logic        obs_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model_accept(input logic rd, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [3:0] m);
    longint unsigned la, lim;
    int unsigned     idx;
    logic            err;
    logic [31:0]     rdv;
    la  = longint'(a);
    lim = longint'(BASE) + longint'(4 * DEPTH);
    rdv = '0;
    err = (a % 4 != 0) || (la < longint'(BASE)) || (la >= lim);
    if (!err) begin
      idx = int'((la - longint'(BASE)) / 4);
      if (rd) rdv = ref_mem[idx];
      else for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    return {err, rdv};
  endfunction

  task automatic set_cmd(input logic v, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m);
    icb_cmd_valid = v;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = m;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then move past the edge.
  task automatic step();
    logic exp_ready, pop;
    @(negedge clk);
    obs_valid    = icb_rsp_valid;
    obs_ready    = icb_cmd_ready;
    last_dut_acc = icb_cmd_valid & icb_cmd_ready;
    if (rst) begin
      check_eq("rst_cmd_ready", icb_cmd_ready, 0);
      check_eq("rst_rsp_valid", icb_rsp_valid, 0);
      check_eq("rst_rsp_rdata", icb_rsp_rdata, 0);
      check_eq("rst_rsp_err",   icb_rsp_err,   0);
      exp_q.delete();
    end else begin
      pop       = (exp_q.size() != 0) && icb_rsp_ready;
      exp_ready = (exp_q.size() < 2) || pop;
      check_eq("cmd_ready", icb_cmd_ready, exp_ready);
      check_eq("rsp_valid", icb_rsp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check_eq("rsp_rdata", icb_rsp_rdata, exp_q[0][31:0]);
        check_eq("rsp_err",   icb_rsp_err,   exp_q[0][32]);
      end
      if (pop) begin
        last_rdata = icb_rsp_rdata;
        last_err   = icb_rsp_err;
        void'(exp_q.pop_front());
      end
      if (icb_cmd_valid && exp_ready)
        exp_q.push_back(model_accept(icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    set_cmd(1'b0, 1'b0, '0, '0, '0);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 4 * $urandom_range(0, DEPTH - 1);
    else if (r == 7) return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
    else if (r == 8) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
    else             return BASE - 4 * $urandom_range(1, 16);
  endfunction

  initial begin
    int unsigned acc_cnt;

    set_cmd(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    icb_rsp_ready = 1'b1;

    // Fill every word so later reads have defined data; first one lands right after reset.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      set_cmd(1'b1, 1'b0, BASE + 4 * i, $urandom, 4'hF);
      step();
      if (i == 0) check_eq("ready_after_rst", obs_ready, 1);
    end
    idle(3);

    // Full-word write then read back.
    set_cmd(1'b1, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF); step();
    set_cmd(1'b1, 1'b1, 32'h1000_0010, '0, '0);              step();
    check_eq("wr_rsp_rdata", last_rdata, 0);
    check_eq("wr_rsp_err",   last_err,   0);
    idle(1);
    check_eq("rd_deadbeef", last_rdata, 32'hDEAD_BEEF);
    check_eq("rd_deadbeef_err", last_err, 0);

    // Byte-masked merge.
    set_cmd(1'b1, 1'b0, BASE, 32'h1122_3344, 4'b1111); step();
    set_cmd(1'b1, 1'b0, BASE, 32'hAABB_CCDD, 4'b0101); step();
    set_cmd(1'b1, 1'b1, BASE, '0, '0);                 step();
    idle(1);
    check_eq("mask_merge", last_rdata, 32'h11BB_33DD);

    // Misaligned and out-of-window, then word 0 is untouched; last word in range.
    set_cmd(1'b1, 1'b1, 32'h1000_0402, '0, '0); step();
    set_cmd(1'b1, 1'b1, 32'h1000_0400, '0, '0); step();
    check_eq("misalign_err",   last_err,   1);
    check_eq("misalign_rdata", last_rdata, 0);
    set_cmd(1'b1, 1'b1, BASE, '0, '0); step();
    check_eq("oob_err",   last_err,   1);
    check_eq("oob_rdata", last_rdata, 0);
    set_cmd(1'b1, 1'b1, BASE + 4 * (DEPTH - 1), '0, '0); step();
    check_eq("word0_kept", last_rdata, 32'h11BB_33DD);
    idle(2);

    // Backpressure: two accepted, third stalls until the pop cycle.
    icb_rsp_ready = 1'b0;
    set_cmd(1'b1, 1'b1, BASE,     '0, '0); step();
    set_cmd(1'b1, 1'b1, BASE + 4, '0, '0); step();
    set_cmd(1'b1, 1'b1, BASE + 8, '0, '0); step();
    check_eq("full_ready", obs_ready, 0);
    icb_rsp_ready = 1'b1;
    step();
    check_eq("pop_cycle_acc", last_dut_acc, 1);
    idle(3);

    // Sixteen back-to-back reads.
    acc_cnt = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      set_cmd(1'b1, 1'b1, BASE + 4 * $urandom_range(0, DEPTH - 1), '0, '0);
      step();
      if (last_dut_acc) acc_cnt++;
      if (i == 1) check_eq("first_rsp_latency", obs_valid, 1);
    end
    check_eq("b2b_accepts", acc_cnt, 16);
    idle(3);

    // Reset with two responses buffered; memory contents survive.
    icb_rsp_ready = 1'b0;
    set_cmd(1'b1, 1'b0, BASE + 20, 32'hCAFE_F00D, 4'hF); step();
    set_cmd(1'b1, 1'b1, BASE, '0, '0);                   step();
    set_cmd(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    step();
    check_eq("rst_drops_valid", obs_valid, 0);
    step();
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    set_cmd(1'b1, 1'b1, BASE + 20, '0, '0); step();
    idle(1);
    check_eq("mem_after_rst", last_rdata, 32'hCAFE_F00D);

    // Random traffic with random response backpressure.
    for (int unsigned i = 0; i < 800; i++) begin
      set_cmd(($urandom_range(0, 3) != 0), $urandom_range(0, 1), rand_addr(), $urandom,
              4'($urandom_range(0, 15)));
      icb_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    icb_rsp_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
